// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch queue: issues sequential one-cycle-latency reads and
// buffers returned instructions with their PCs for the fetch unit.
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               holt,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ir_valid,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    input  logic               ir_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     used;
    logic               push;
    logic               pop;

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];

    // Credit counts the in-flight read so a returning response always has a slot.
    assign used      = (CNT_W + 1)'(count) + (CNT_W + 1)'(inflight);
    assign imem_req  = !rst && !holt && !redirect_valid && (used < DEPTH_C);
    assign imem_addr = fetch_pc;

    assign push     = !rst && !redirect_valid && imem_rvalid && inflight;
    assign ir_valid = (count != '0);
    assign pop      = ir_valid && ir_ready;

    assign ir    = ir_valid ? instr_mem[head] : '0;
    assign ir_pc = ir_valid ? pc_mem[head]    : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail] <= imem_rdata;
            pc_mem[tail]    <= inflight_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_ADDR;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc    <= fetch_pc + ADDR_W'(1);
                inflight_pc <= fetch_pc;
            end
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: queue-based reference of what the fetch unit
// should receive, with a memory responder driven by the bench.
module tb_instr_prefetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        holt;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        ir_valid;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_ready;

    instr_prefetch_buffer #(
        .DEPTH(DEPTH), .ADDR_W(16), .INSTR_W(16), .RESET_PC(0)
    ) dut (
        .clk(clk), .rst(rst), .holt(holt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready)
    );

    always #5 clk = ~clk;

    // Expected entries as {pc, instr}, in the order the fetch unit must see them.
    logic [31:0] exp_q[$];
    logic [15:0] m_fetch;
    logic        req_prev  = 1'b0;
    logic [15:0] addr_prev = '0;
    logic        mon_en    = 1'b0;
    int          n_cmp     = 0;
    int          n_bad     = 0;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return a + 16'h1000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the reference queue each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_req;
            int   occupied;
            occupied = exp_q.size() + (req_prev ? 1 : 0);
            exp_req  = !rst && !holt && !redirect_valid && (occupied < DEPTH);
            chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
            chk("imem_addr", {16'd0, imem_addr}, {16'd0, m_fetch});
            chk("ir_valid", {31'd0, ir_valid}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                chk("ir_pc", {16'd0, ir_pc}, {16'd0, exp_q[0][31:16]});
                chk("ir", {16'd0, ir}, {16'd0, exp_q[0][15:0]});
                if (ir_ready) void'(exp_q.pop_front());
            end else begin
                chk("ir_empty", {ir, ir_pc}, 32'd0);
            end
        end
    end

    // One clock of stimulus; the memory answers last cycle's request.
    task automatic cyc(input logic r, input logic h, input logic rv,
                       input logic [15:0] rpc, input logic rdy, input logic spur);
        logic        real_resp;
        logic [15:0] data;
        @(posedge clk);
        #1;
        real_resp      = req_prev;
        data           = req_prev ? mem_f(addr_prev) : 16'($urandom);
        rst            = r;
        holt           = h;
        redirect_valid = rv;
        redirect_pc    = rpc;
        ir_ready       = rdy;
        imem_rvalid    = req_prev | spur;
        imem_rdata     = data;
        @(negedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            m_fetch = 16'h0000;
        end else if (rv) begin
            exp_q.delete();
            m_fetch = rpc;
        end else begin
            if (real_resp) exp_q.push_back({addr_prev, data});
            if (imem_req) m_fetch = m_fetch + 16'd1;
        end
        req_prev  = imem_req;
        addr_prev = imem_addr;
    endtask

    task automatic run(input int n, input logic h, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, h, 1'b0, 16'h0, rdy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; holt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        ir_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        m_fetch = '0;
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        mon_en = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        run(10, 1'b0, 1'b1);
        run(12, 1'b0, 1'b0);
        run(8, 1'b0, 1'b1);
        run(3, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b0);
        run(8, 1'b0, 1'b1);
        run(5, 1'b1, 1'b1);
        run(8, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        run(10, 1'b0, 1'b1);
        run(6, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        run(8, 1'b0, 1'b1);
        // Spurious rvalid with nothing in flight must be ignored.
        run(6, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        run(6, 1'b0, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            logic        r, h, rv, rdy, sp;
            logic [15:0] rpc;
            r   = ($urandom_range(99) < 1);
            rv  = ($urandom_range(99) < 5);
            h   = ($urandom_range(99) < 20);
            rdy = ($urandom_range(99) < 70);
            sp  = ($urandom_range(99) < 10);
            rpc = ($urandom_range(3) == 0) ? 16'(16'hFFFC + $urandom_range(3)) : 16'($urandom);
            cyc(r, h, rv, rpc, rdy, sp);
        end
        run(10, 1'b0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
